// File: rtl/hps_fpga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hps_fpga_pkg
//  Description : Shared definitions for the HPS<->FPGA mailbox: register
//                offsets, STATUS/CONTROL/FLAGS bit positions and a helper
//                that packs the STATUS word.
//  Ports       : (package, none)
//  Revision    : 1.0 - initial release
// ============================================================================
package hps_fpga_pkg;

  // Register offsets within a channel (avs_address[1:0])
  localparam logic [1:0] c_reg_data    = 2'd0;
  localparam logic [1:0] c_reg_status  = 2'd1;
  localparam logic [1:0] c_reg_control = 2'd2;
  localparam logic [1:0] c_reg_flags   = 2'd3;

  // STATUS bit positions
  localparam int c_st_tx_lvl_lsb = 0;
  localparam int c_st_rx_lvl_lsb = 8;
  localparam int c_st_tx_full    = 16;
  localparam int c_st_rx_empty   = 17;
  localparam int c_st_tx_ovf     = 18;
  localparam int c_st_rx_unf     = 19;

  // CONTROL bit positions (flush bits are strobes and read back as 0)
  localparam int c_ctl_tx_flush = 0;
  localparam int c_ctl_rx_flush = 1;
  localparam int c_ctl_irq_en   = 2;

  // FLAGS bit positions (write 1 to clear)
  localparam int c_flg_tx_ovf = 0;
  localparam int c_flg_rx_unf = 1;

  function automatic logic [31:0] pack_status(
    input logic [7:0] tx_lvl,
    input logic [7:0] rx_lvl,
    input logic       tx_full,
    input logic       rx_empty,
    input logic       tx_ovf,
    input logic       rx_unf
  );
    logic [31:0] s;
    s = '0;
    s[c_st_tx_lvl_lsb +: 8] = tx_lvl;
    s[c_st_rx_lvl_lsb +: 8] = rx_lvl;
    s[c_st_tx_full]         = tx_full;
    s[c_st_rx_empty]        = rx_empty;
    s[c_st_tx_ovf]          = tx_ovf;
    s[c_st_rx_unf]          = rx_unf;
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mbox_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : mbox_sync_fifo
//  Description : Single-clock FIFO with flush and occupancy level. Full and
//                empty come from the registered level, so a push into a full
//                FIFO is dropped even if a pop happens the same cycle, and a
//                word pushed into an empty FIFO shows up one cycle later.
//  Ports       : clk, rst (async, active high)
//                push/push_data - write request (ignored when full)
//                pop            - read request (ignored when empty)
//                flush          - empties the FIFO, overrides push/pop
//                head           - word at the read pointer
//                level/full/empty - occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module mbox_sync_fifo
  import hps_fpga_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 16,
  localparam int AW     = $clog2(DEPTH),
  localparam int LW     = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              flush,
  output logic [DATA_W-1:0] head,
  output logic [LW-1:0]     level,
  output logic              full,
  output logic              empty
);

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              do_push, do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push & ~full  & ~flush;
  assign do_pop  = pop  & ~empty & ~flush;
  assign level   = level_q;
  assign head    = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: the level alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/hps_fpga_mailbox.sv
`default_nettype none
// ============================================================================
//  Module      : hps_fpga_mailbox
//  Description : Multi-channel HPS<->FPGA mailbox. Each channel has a TX FIFO
//                (HPS writes DATA, FPGA drains a valid/ready stream) and an RX
//                FIFO (FPGA pushes a valid/ready stream, HPS reads DATA).
//                Avalon-MM slave, zero wait states, one-cycle read latency.
//  Ports       : clk_clk, reset_reset (async, active high)
//                avs_*         - Avalon-MM slave, address = {channel, reg}
//                tx_*          - HPS-to-FPGA streams, one lane per channel
//                rx_*          - FPGA-to-HPS streams, one lane per channel
//                irq           - interrupt to HPS
//  Options     : HPS_MBOX_IRQ_EN - per-channel irq_en in CONTROL[2] and a
//                registered irq; without it irq is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module hps_fpga_mailbox
  import hps_fpga_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 16,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int LW     = $clog2(DEPTH) + 1
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset,
  input  logic [CH_W+1:0]          avs_address,
  input  logic                     avs_write,
  input  logic                     avs_read,
  input  logic [DATA_W-1:0]        avs_writedata,
  output logic [DATA_W-1:0]        avs_readdata,
  output logic                     avs_readdatavalid,
  output logic [NUM_CH*DATA_W-1:0] tx_data,
  output logic [NUM_CH-1:0]        tx_valid,
  input  logic [NUM_CH-1:0]        tx_ready,
  input  logic [NUM_CH*DATA_W-1:0] rx_data,
  input  logic [NUM_CH-1:0]        rx_valid,
  output logic [NUM_CH-1:0]        rx_ready,
  output logic                     irq
);

  logic [CH_W-1:0] acc_ch;
  logic [1:0]      acc_reg;
  logic            acc_ch_ok;
  logic            wr_en, rd_en;

  assign acc_ch    = avs_address[CH_W+1:2];
  assign acc_reg   = avs_address[1:0];
  assign acc_ch_ok = (int'(acc_ch) < NUM_CH);
  // A cycle with both strobes is a no-op; reads of absent channels still
  // complete (returning 0), writes to them are dropped.
  assign wr_en     = avs_write & ~avs_read & acc_ch_ok;
  assign rd_en     = avs_read & ~avs_write;

  logic [LW-1:0]     tx_level [NUM_CH];
  logic [LW-1:0]     rx_level [NUM_CH];
  logic [DATA_W-1:0] rx_head  [NUM_CH];
  logic [NUM_CH-1:0] tx_full, tx_empty, rx_full, rx_empty;
  logic [NUM_CH-1:0] tx_ovf_set, tx_ovf_clr, rx_unf_set, rx_unf_clr, ctl_wr;
  logic [NUM_CH-1:0] tx_ovf_q, tx_ovf_d, rx_unf_q, rx_unf_d;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic sel, data_wr, data_rd;

    assign sel     = acc_ch_ok && (acc_ch == CH_W'(i));
    assign data_wr = wr_en & sel & (acc_reg == c_reg_data);
    assign data_rd = rd_en & sel & (acc_reg == c_reg_data);
    assign ctl_wr[i] = wr_en & sel & (acc_reg == c_reg_control);

    // Over/underflow judged on the pre-cycle level, same as the FIFO.
    assign tx_ovf_set[i] = data_wr & tx_full[i];
    assign rx_unf_set[i] = data_rd & rx_empty[i];
    assign tx_ovf_clr[i] = wr_en & sel & (acc_reg == c_reg_flags) & avs_writedata[c_flg_tx_ovf];
    assign rx_unf_clr[i] = wr_en & sel & (acc_reg == c_reg_flags) & avs_writedata[c_flg_rx_unf];

    mbox_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
      .clk       (clk_clk),
      .rst       (reset_reset),
      .push      (data_wr),
      .push_data (avs_writedata),
      .pop       (tx_ready[i]),
      .flush     (ctl_wr[i] & avs_writedata[c_ctl_tx_flush]),
      .head      (tx_data[i*DATA_W +: DATA_W]),
      .level     (tx_level[i]),
      .full      (tx_full[i]),
      .empty     (tx_empty[i])
    );

    mbox_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
      .clk       (clk_clk),
      .rst       (reset_reset),
      .push      (rx_valid[i]),
      .push_data (rx_data[i*DATA_W +: DATA_W]),
      .pop       (data_rd),
      .flush     (ctl_wr[i] & avs_writedata[c_ctl_rx_flush]),
      .head      (rx_head[i]),
      .level     (rx_level[i]),
      .full      (rx_full[i]),
      .empty     (rx_empty[i])
    );

    assign tx_valid[i] = ~tx_empty[i];
    assign rx_ready[i] = ~rx_full[i];
  end

  // Sticky flags: a same-cycle set beats the write-1-to-clear.
  always_comb begin
    tx_ovf_d = tx_ovf_set | (tx_ovf_q & ~tx_ovf_clr);
    rx_unf_d = rx_unf_set | (rx_unf_q & ~rx_unf_clr);
  end

`ifdef HPS_MBOX_IRQ_EN
  logic [NUM_CH-1:0] irq_en_q, irq_en_d;
  logic              irq_q, irq_d;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      irq_en_d[i] = ctl_wr[i] ? avs_writedata[c_ctl_irq_en] : irq_en_q[i];
    end
    irq_d = (|(irq_en_q & ~rx_empty)) | (|tx_ovf_q) | (|rx_unf_q);
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      irq_en_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  // Read mux: sampled from pre-cycle state, registered into readdata.
  logic [DATA_W-1:0] rd_val;

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (acc_ch_ok && (acc_ch == CH_W'(i))) begin
        case (acc_reg)
          c_reg_data:    rd_val = rx_empty[i] ? '0 : rx_head[i];
          c_reg_status:  rd_val = DATA_W'(pack_status(8'(tx_level[i]), 8'(rx_level[i]),
                                                      tx_full[i], rx_empty[i],
                                                      tx_ovf_q[i], rx_unf_q[i]));
          c_reg_control: begin
`ifdef HPS_MBOX_IRQ_EN
            rd_val[c_ctl_irq_en] = irq_en_q[i];
`endif
          end
          default: begin
            rd_val[c_flg_tx_ovf] = tx_ovf_q[i];
            rd_val[c_flg_rx_unf] = rx_unf_q[i];
          end
        endcase
      end
    end
  end

  logic [DATA_W-1:0] readdata_q, readdata_d;
  logic              readdatavalid_q, readdatavalid_d;

  always_comb begin
    readdata_d      = rd_en ? rd_val : readdata_q;
    readdatavalid_d = rd_en;
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      readdata_q      <= '0;
      readdatavalid_q <= 1'b0;
      tx_ovf_q        <= '0;
      rx_unf_q        <= '0;
    end else begin
      readdata_q      <= readdata_d;
      readdatavalid_q <= readdatavalid_d;
      tx_ovf_q        <= tx_ovf_d;
      rx_unf_q        <= rx_unf_d;
    end
  end

  assign avs_readdata      = readdata_q;
  assign avs_readdatavalid = readdatavalid_q;

endmodule
`default_nettype wire

// File: tb/tb_hps_fpga_mailbox.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_hps_fpga_mailbox
//  Description : Self-checking bench for hps_fpga_mailbox. Directed scenarios
//                followed by random traffic, all checked against a queue-based
//                reference model of the mailbox.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hps_fpga_mailbox;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int CH_W   = 2;

  logic                     clk_clk = 1'b0;
  logic                     reset_reset = 1'b1;
  logic [CH_W+1:0]          avs_address = '0;
  logic                     avs_write = 1'b0;
  logic                     avs_read = 1'b0;
  logic [DATA_W-1:0]        avs_writedata = '0;
  logic [DATA_W-1:0]        avs_readdata;
  logic                     avs_readdatavalid;
  logic [NUM_CH*DATA_W-1:0] tx_data;
  logic [NUM_CH-1:0]        tx_valid;
  logic [NUM_CH-1:0]        tx_ready = '0;
  logic [NUM_CH*DATA_W-1:0] rx_data = '0;
  logic [NUM_CH-1:0]        rx_valid = '0;
  logic [NUM_CH-1:0]        rx_ready;
  logic                     irq;

  always #5 clk_clk = ~clk_clk;

  hps_fpga_mailbox #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk_clk           (clk_clk),
    .reset_reset       (reset_reset),
    .avs_address       (avs_address),
    .avs_write         (avs_write),
    .avs_read          (avs_read),
    .avs_writedata     (avs_writedata),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .tx_data           (tx_data),
    .tx_valid          (tx_valid),
    .tx_ready          (tx_ready),
    .rx_data           (rx_data),
    .rx_valid          (rx_valid),
    .rx_ready          (rx_ready),
    .irq               (irq)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: plain queues per channel plus sticky flag bits.
  logic [31:0]       m_tx [NUM_CH][$];
  logic [31:0]       m_rx [NUM_CH][$];
  logic [NUM_CH-1:0] m_ovf = '0;
  logic [NUM_CH-1:0] m_unf = '0;
  logic [NUM_CH-1:0] m_ien = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_status(input int c);
    logic [31:0] s;
    s        = '0;
    s[7:0]   = 8'(m_tx[c].size());
    s[15:8]  = 8'(m_rx[c].size());
    s[16]    = (m_tx[c].size() == DEPTH);
    s[17]    = (m_rx[c].size() == 0);
    s[18]    = m_ovf[c];
    s[19]    = m_unf[c];
    return s;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_tx[i].delete();
      m_rx[i].delete();
    end
    m_ovf = '0;
    m_unf = '0;
    m_ien = '0;
  endtask

  // One bus cycle: check pre-edge outputs, drive, advance the model, clock,
  // then check the registered read response and irq.
  task automatic cycle(input logic w, input logic r, input int ch,
                       input logic [1:0] rg, input logic [31:0] d);
    logic [NUM_CH-1:0] exp_tv, exp_rr;
    logic              exp_rv, exp_irq;
    logic [31:0]       exp_rd;
    int                tsz, rsz;
    logic              wsel, rsel, tpush, tflush, rflush, rpop, new_ovf, new_unf;

    for (int i = 0; i < NUM_CH; i++) begin
      exp_tv[i] = (m_tx[i].size() != 0);
      exp_rr[i] = (m_rx[i].size() < DEPTH);
    end
    chk("tx_valid", tx_valid, exp_tv);
    chk("rx_ready", rx_ready, exp_rr);
    for (int i = 0; i < NUM_CH; i++)
      if (exp_tv[i]) chk($sformatf("tx_data[%0d]", i), tx_data[i*DATA_W +: DATA_W], m_tx[i][0]);

    avs_write     = w;
    avs_read      = r;
    avs_address   = {CH_W'(ch), rg};
    avs_writedata = d;

    exp_irq = 1'b0;
`ifdef HPS_MBOX_IRQ_EN
    for (int i = 0; i < NUM_CH; i++)
      if ((m_ien[i] && m_rx[i].size() != 0) || m_ovf[i] || m_unf[i]) exp_irq = 1'b1;
`endif

    exp_rv = r && !w;
    exp_rd = '0;
    if (exp_rv) begin
      case (rg)
        2'd0:    exp_rd = (m_rx[ch].size() != 0) ? m_rx[ch][0] : 32'h0;
        2'd1:    exp_rd = m_status(ch);
`ifdef HPS_MBOX_IRQ_EN
        2'd2:    exp_rd = {29'h0, m_ien[ch], 2'b00};
`else
        2'd2:    exp_rd = 32'h0;
`endif
        default: exp_rd = {30'h0, m_unf[ch], m_ovf[ch]};
      endcase
    end

    for (int i = 0; i < NUM_CH; i++) begin
      tsz     = m_tx[i].size();
      rsz     = m_rx[i].size();
      wsel    = w && !r && (ch == i);
      rsel    = exp_rv && (ch == i);
      tpush   = wsel && (rg == 2'd0);
      tflush  = wsel && (rg == 2'd2) && d[0];
      rflush  = wsel && (rg == 2'd2) && d[1];
      rpop    = rsel && (rg == 2'd0);
      new_ovf = tpush && (tsz == DEPTH);
      new_unf = rpop && (rsz == 0);
      if (tflush) m_tx[i].delete();
      else begin
        if (tx_ready[i] && tsz > 0) void'(m_tx[i].pop_front());
        if (tpush && tsz < DEPTH) m_tx[i].push_back(d);
      end
      if (rflush) m_rx[i].delete();
      else begin
        if (rpop && rsz > 0) void'(m_rx[i].pop_front());
        if (rx_valid[i] && rsz < DEPTH) m_rx[i].push_back(rx_data[i*DATA_W +: DATA_W]);
      end
      if (wsel && rg == 2'd3) begin
        m_ovf[i] = new_ovf || (m_ovf[i] && !d[0]);
        m_unf[i] = new_unf || (m_unf[i] && !d[1]);
      end else begin
        m_ovf[i] = m_ovf[i] || new_ovf;
        m_unf[i] = m_unf[i] || new_unf;
      end
`ifdef HPS_MBOX_IRQ_EN
      if (wsel && rg == 2'd2) m_ien[i] = d[2];
`endif
    end

    @(posedge clk_clk);
    #1;
    chk("readdatavalid", avs_readdatavalid, exp_rv);
    if (exp_rv) chk("readdata", avs_readdata, exp_rd);
    chk("irq", irq, exp_irq);
    avs_write = 1'b0;
    avs_read  = 1'b0;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 0, 2'd0, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] words [17];
    logic [31:0] last;
    int          n;
    int          op, ch;
    logic [1:0]  rg;
    logic [31:0] d;

    // ---------------- reset ----------------
    m_reset();
    repeat (3) @(posedge clk_clk);
    #1;
    chk("rst_readdatavalid", avs_readdatavalid, 1'b0);
    chk("rst_readdata", avs_readdata, 32'h0);
    chk("rst_tx_valid", tx_valid, 4'h0);
    chk("rst_irq", irq, 1'b0);
    reset_reset = 1'b0;
    @(posedge clk_clk);
    #1;
    chk("post_rst_rx_ready", rx_ready, 4'hF);
    chk("post_rst_tx_valid", tx_valid, 4'h0);
    chk("post_rst_readdatavalid", avs_readdatavalid, 1'b0);
    chk("post_rst_readdata", avs_readdata, 32'h0);
    idle();

    // ---------------- 3 DATA writes ch1, tx_ready low ----------------
    for (int k = 0; k < 3; k++) begin
      words[k] = $urandom;
      cycle(1'b1, 1'b0, 1, 2'd0, words[k]);
    end
    cycle(1'b0, 1'b1, 1, 2'd1, 32'h0);
    chk("ch1_tx_level", avs_readdata[7:0], 8'd3);
    chk("ch1_tx_valid", tx_valid[1], 1'b1);
    chk("ch1_head", tx_data[63:32], words[0]);

    // ---------------- 17 writes ch0 -> overflow ----------------
    for (int k = 0; k < 17; k++) begin
      words[k] = $urandom;
      cycle(1'b1, 1'b0, 0, 2'd0, words[k]);
    end
    cycle(1'b0, 1'b1, 0, 2'd1, 32'h0);
    chk("ch0_level_full", avs_readdata[7:0], 8'd16);
    chk("ch0_tx_full", avs_readdata[16], 1'b1);
    chk("ch0_tx_ovf", avs_readdata[18], 1'b1);
    tx_ready[0] = 1'b1;
    n = 0;
    last = '0;
    for (int k = 0; k < 20; k++) begin
      if (tx_valid[0]) begin
        if (n < 17) chk($sformatf("ch0_drain_%0d", n), tx_data[31:0], words[n]);
        last = tx_data[31:0];
        n++;
      end
      idle();
    end
    chk("ch0_emitted_count", n, 16);
    chk("ch0_last_emitted", last, words[15]);
    tx_ready[0] = 1'b0;
    cycle(1'b1, 1'b0, 0, 2'd3, 32'h1);
    cycle(1'b0, 1'b1, 0, 2'd1, 32'h0);
    chk("ch0_ovf_cleared", avs_readdata[18], 1'b0);

    // ---------------- RX underflow on ch0 ----------------
    cycle(1'b0, 1'b1, 0, 2'd0, 32'h0);
    chk("unf_readdatavalid", avs_readdatavalid, 1'b1);
    chk("unf_readdata", avs_readdata, 32'h0);
    cycle(1'b0, 1'b1, 0, 2'd1, 32'h0);
    chk("rx_unf_set", avs_readdata[19], 1'b1);
    cycle(1'b1, 1'b0, 0, 2'd3, 32'h2);
    cycle(1'b0, 1'b1, 0, 2'd1, 32'h0);
    chk("rx_unf_clear", avs_readdata[19], 1'b0);

    // ---------------- RX push ch2 ----------------
    rx_valid[2] = 1'b1;
    rx_data[95:64] = 32'hA5A5A5A5;
    idle();
    rx_valid = '0;
    cycle(1'b0, 1'b1, 2, 2'd0, 32'h0);
    chk("ch2_rx_word", avs_readdata, 32'hA5A5A5A5);
    cycle(1'b0, 1'b1, 2, 2'd1, 32'h0);
    chk("ch2_rx_empty", avs_readdata[17], 1'b1);

    // ---------------- flush beats pop on ch3 ----------------
    for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, 3, 2'd0, $urandom);
    cycle(1'b0, 1'b1, 3, 2'd1, 32'h0);
    chk("ch3_level5", avs_readdata[7:0], 8'd5);
    tx_ready[3] = 1'b1;
    cycle(1'b1, 1'b0, 3, 2'd2, 32'h1);
    chk("ch3_flush_tx_valid", tx_valid[3], 1'b0);
    tx_ready[3] = 1'b0;
    cycle(1'b0, 1'b1, 3, 2'd1, 32'h0);
    chk("ch3_flush_level", avs_readdata[7:0], 8'd0);

    // ---------------- read+write together is ignored ----------------
    cycle(1'b1, 1'b1, 1, 2'd0, 32'hDEADBEEF);
    chk("rw_no_readdatavalid", avs_readdatavalid, 1'b0);
    cycle(1'b0, 1'b1, 1, 2'd1, 32'h0);
    chk("rw_level_kept", avs_readdata[7:0], 8'd3);

`ifdef HPS_MBOX_IRQ_EN
    // ---------------- irq from RX on ch3 ----------------
    cycle(1'b1, 1'b0, 3, 2'd2, 32'h4);
    rx_valid[3] = 1'b1;
    rx_data[127:96] = $urandom;
    idle();
    rx_valid = '0;
    idle();
    chk("irq_rx_ch3", irq, 1'b1);
    cycle(1'b0, 1'b1, 3, 2'd0, 32'h0);
    cycle(1'b1, 1'b0, 3, 2'd2, 32'h0);
`endif

    // ---------------- random traffic ----------------
    for (int k = 0; k < 400; k++) begin
      tx_ready = NUM_CH'($urandom & $urandom);
      rx_valid = NUM_CH'($urandom);
      for (int i = 0; i < NUM_CH; i++) rx_data[i*DATA_W +: DATA_W] = $urandom;
      op = int'($urandom_range(0, 9));
      ch = int'($urandom_range(0, NUM_CH - 1));
      rg = 2'($urandom_range(0, 3));
      d  = $urandom;
      if (rg == 2'd2 && $urandom_range(0, 3) != 0) d = d & ~32'h3;
      if (op <= 3)      cycle(1'b1, 1'b0, ch, rg, d);
      else if (op <= 6) cycle(1'b0, 1'b1, ch, rg, d);
      else if (op == 7) cycle(1'b1, 1'b1, ch, rg, d);
      else              cycle(1'b0, 1'b0, ch, rg, d);
    end
    tx_ready = '0;
    rx_valid = '0;

    // ---------------- reset during an outstanding read ----------------
    avs_read    = 1'b1;
    avs_address = {CH_W'(1), 2'd1};
    #2;
    reset_reset = 1'b1;
    m_reset();
    @(posedge clk_clk);
    #1;
    chk("rst_midread_rdv", avs_readdatavalid, 1'b0);
    chk("rst_midread_irq", irq, 1'b0);
    avs_read = 1'b0;
    @(posedge clk_clk);
    #1;
    chk("rst_midread_rdv2", avs_readdatavalid, 1'b0);
    chk("rst_midread_tx_valid", tx_valid, 4'h0);
    reset_reset = 1'b0;
    @(posedge clk_clk);
    #1;
    chk("rst_release_rx_ready", rx_ready, 4'hF);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
